// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//
// Runtime-configurable UART transmitter. A byte-wide (up to DATA_MAX bits)
// valid/ready input feeds a one-entry holding buffer. The frame engine pulls
// the buffered word together with the current line configuration into its
// own shifter and serialises:
//
//   start (0) | data[0 .. data_bits-1] LSB first | [parity] | stop (1) x1/x2
//
// Every serial bit lasts clks_per_bit clock cycles. A word that is already
// buffered when the final stop cycle ends starts its frame on the very next
// cycle, so back-to-back frames have no idle gap on the line.
//
// Parameters
//   DATA_MAX      widest data field supported (5..9), width of tx_data
//   DIV_WIDTH     width of clks_per_bit
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous reset, active low
//   tx_data       word to send; bits above data_bits are ignored
//   tx_valid      tx_data is valid
//   tx_ready      holding buffer empty (transfer on tx_valid & tx_ready)
//   clks_per_bit  clock cycles per serial bit, 0 behaves as 1
//   data_bits     data field length, clamped to 5..DATA_MAX
//   parity_mode   00 none, 01 even, 10 odd, 11 none
//   stop_bits     0 one stop bit, 1 two stop bits
//   tx_s          serial line, registered, idles high
//   busy          a frame is in progress
//   frame_done    one-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_cfg #(
    parameter int DATA_MAX  = 9,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_MAX-1:0]  tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DIV_WIDTH-1:0] clks_per_bit,
    input  logic [3:0]           data_bits,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic                 tx_s,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] NBITS_MIN = 4'd5;
    localparam logic [3:0] NBITS_MAX = 4'(DATA_MAX);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;        // cycles elapsed in the current bit
    logic [3:0]            r_bit_idx;    // data bit being sent
    logic                  r_stop_idx;   // 0 first stop bit, 1 second
    logic                  r_tx_s;

    logic                  r_hold_full;
    logic [DATA_MAX-1:0]   r_hold_data;

    // Frame configuration captured at load; the live inputs are ignored
    // until the next frame is loaded.
    logic [DATA_MAX-1:0]   r_shift;
    logic [DIV_WIDTH-1:0]  r_cpb;        // already forced to >= 1
    logic [3:0]            r_nbits;      // already clamped
    logic                  r_par_en;
    logic                  r_par_odd;
    logic                  r_stop2;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [DIV_WIDTH-1:0]  w_cnt_nxt;
    logic [3:0]            w_bit_idx_nxt;
    logic                  w_stop_idx_nxt;
    logic                  w_tx_nxt;
    logic                  w_load;
    logic                  w_frame_done;
    logic                  w_bit_end;
    logic                  w_handshake;
    logic [DATA_MAX-1:0]   w_mask;
    logic                  w_parity;
    logic [3:0]            w_nbits_clamped;
    logic [DIV_WIDTH-1:0]  w_cpb_eff;

    assign tx_ready    = !r_hold_full;
    assign busy        = (r_state != IDLE);
    assign frame_done  = w_frame_done;
    assign tx_s        = r_tx_s;

    // tx_ready depends only on the holding register, so this handshake has
    // no combinational path from tx_valid back to tx_ready.
    assign w_handshake = tx_valid && !r_hold_full;

    // The last cycle of a bit period; r_cpb is never zero once loaded.
    assign w_bit_end   = (r_cnt == r_cpb - DIV_WIDTH'(1));

    // Configuration sanitising applied at load time.
    assign w_cpb_eff       = (clks_per_bit == '0) ? DIV_WIDTH'(1) : clks_per_bit;
    assign w_nbits_clamped = (data_bits < NBITS_MIN) ? NBITS_MIN :
                             (data_bits > NBITS_MAX) ? NBITS_MAX : data_bits;

    // Parity covers only the active data bits of the loaded word.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_MAX; i++) begin
            w_mask[i] = (i < int'(r_nbits));
        end
    end

    assign w_parity = (^(r_shift & w_mask)) ^ r_par_odd;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = '0;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_load         = 1'b0;
        w_frame_done   = 1'b0;
        w_tx_nxt       = 1'b1;

        // Bit-period counter restarts at every bit boundary.
        if (r_state != IDLE) begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + DIV_WIDTH'(1);
        end

        unique case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = 4'd0;
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == r_nbits - 4'd1) begin
                        w_state_nxt    = r_par_en ? PARITY : STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end

            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt    = STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_idx) begin
                        w_stop_idx_nxt = 1'b1;
                    end else begin
                        // Final stop cycle: pulse done and either chain the
                        // buffered word straight into a new start bit or idle.
                        w_frame_done = 1'b1;
                        if (r_hold_full) begin
                            w_load      = 1'b1;
                            w_state_nxt = START;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // The line level is registered, so it is decoded from where the
        // machine will be next cycle.
        unique case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = r_shift[w_bit_idx_nxt];
            PARITY:  w_tx_nxt = w_parity;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 4'd0;
            r_stop_idx <= 1'b0;
            r_tx_s     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx_s     <= w_tx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Holding buffer
    // ------------------------------------------------------------------
    // A handshake needs an empty buffer and a load needs a full one, so the
    // two can never happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_full <= 1'b0;
        end else if (w_handshake) begin
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // NOTE: payload and captured configuration are not reset; they are only
    // consumed after a handshake or load has written them, which the reset
    // control flags above guarantee.
    always_ff @(posedge clk) begin
        if (w_handshake) begin
            r_hold_data <= tx_data;
        end
        if (w_load) begin
            r_shift   <= r_hold_data;
            r_cpb     <= w_cpb_eff;
            r_nbits   <= w_nbits_clamped;
            r_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            r_par_odd <= (parity_mode == 2'b10);
            r_stop2   <= stop_bits;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps

module tb_uart_tx_cfg;

    localparam int DATA_MAX  = 9;
    localparam int DIV_WIDTH = 16;

    logic                 clk;
    logic                 rst;
    logic [DATA_MAX-1:0]  tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DIV_WIDTH-1:0] clks_per_bit;
    logic [3:0]           data_bits;
    logic [1:0]           parity_mode;
    logic                 stop_bits;
    logic                 tx_s;
    logic                 busy;
    logic                 frame_done;

    uart_tx_cfg #(.DATA_MAX(DATA_MAX), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .clks_per_bit (clks_per_bit),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .tx_s         (tx_s),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the expected line level of every remaining cycle of
    // the current frame is held in a queue; the front entry is this cycle.
    // ------------------------------------------------------------------
    logic                tl[$];
    logic                m_full;
    logic [DATA_MAX-1:0] m_data;
    bit                  cmp_en = 0;

    function automatic int frame_len(input int cpb, input int nb, input int pm, input int st);
        int ce = (cpb == 0) ? 1 : cpb;
        int n  = (nb < 5) ? 5 : ((nb > DATA_MAX) ? DATA_MAX : nb);
        int p  = (pm == 1 || pm == 2) ? 1 : 0;
        return ce * (1 + n + p + (st ? 2 : 1));
    endfunction

    task automatic enqueue_frame(input logic [DATA_MAX-1:0] d, input int cpb,
                                 input int nb, input int pm, input logic st);
        int   ce = (cpb == 0) ? 1 : cpb;
        int   n  = (nb < 5) ? 5 : ((nb > DATA_MAX) ? DATA_MAX : nb);
        logic syms[$];
        logic p = 1'b0;
        syms.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            syms.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm == 1) syms.push_back(p);
        if (pm == 2) syms.push_back(!p);
        syms.push_back(1'b1);
        if (st) syms.push_back(1'b1);
        foreach (syms[i]) repeat (ce) tl.push_back(syms[i]);
    endtask

    always @(posedge clk) begin
        bit ld;
        bit hs;
        if (!rst) begin
            tl.delete();
            m_full = 1'b0;
        end else begin
            ld = m_full && (tl.size() <= 1);
            hs = tx_valid && !m_full;
            if (tl.size() > 0) void'(tl.pop_front());
            if (ld) begin
                enqueue_frame(m_data, int'(clks_per_bit), int'(data_bits),
                              int'(parity_mode), stop_bits);
                m_full = 1'b0;
            end
            if (hs) begin
                m_full = 1'b1;
                m_data = tx_data;
            end
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("tx_s",       32'(tx_s),       32'((tl.size() > 0) ? tl[0] : 1'b1));
            check("busy",       32'(busy),       32'(tl.size() > 0));
            check("frame_done", 32'(frame_done), 32'(tl.size() == 1));
            check("tx_ready",   32'(tx_ready),   32'(!m_full));
        end
    end

    // Busy-run and frame_done bookkeeping for the directed scenarios.
    int run_len  = 0;
    int last_run = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_cfg(input int cpb, input int nb, input int pm, input logic st);
        clks_per_bit = DIV_WIDTH'(cpb);
        data_bits    = 4'(nb);
        parity_mode  = 2'(pm);
        stop_bits    = st;
    endtask

    task automatic push(input logic [DATA_MAX-1:0] word);
        logic r;
        int   guard = 0;
        tx_data  = word;
        tx_valid = 1'b1;
        do begin
            r = tx_ready;
            @(posedge clk);
            #2;
            guard++;
        end while (!r && guard < 500);
        check("push_timeout", 32'(r), 32'd1);
        tx_valid = 1'b0;
    endtask

    // Records the line once per bit period of the next frame.
    task automatic capture(input string name, input int cpb_eff, input int nsym,
                           input logic [15:0] exp_bits, input int exp_len);
        logic [15:0] got = '0;
        int c = 0;
        int done_at = -1;
        int guard = 0;
        @(negedge clk);
        while (!busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_start"}, 32'(busy), 32'd1);
        while (busy && c < 2000) begin
            if ((c % cpb_eff) == 0 && (c / cpb_eff) < 16) got[c / cpb_eff] = tx_s;
            if (frame_done) done_at = c;
            c++;
            @(negedge clk);
        end
        check({name, "_len"},  32'(c), 32'(exp_len));
        check({name, "_bits"}, 32'(got & 16'((32'd1 << nsym) - 1)), 32'(exp_bits));
        check({name, "_done"}, 32'(done_at), 32'(exp_len - 1));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int guard;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        set_cfg(4, 8, 0, 1'b0);
        repeat (2) @(posedge clk);
        cmp_en = 1;
        #2 rst = 1'b1;

        @(negedge clk);
        check("reset_tx_s",     32'(tx_s),       32'd1);
        check("reset_busy",     32'(busy),       32'd0);
        check("reset_done",     32'(frame_done), 32'd0);
        check("reset_ready",    32'(tx_ready),   32'd1);

        // Model arithmetic pinned against hand-computed frame lengths.
        check("len_8N1_cpb4",   32'(frame_len(4, 8, 0, 0)), 32'd40);
        check("len_7E2_cpb2",   32'(frame_len(2, 7, 1, 1)), 32'd22);
        check("len_5N1_cpb0",   32'(frame_len(0, 3, 0, 0)), 32'd7);
        check("len_9O1_cpb1",   32'(frame_len(1, 9, 2, 0)), 32'd12);

        @(posedge clk); #2;
        set_cfg(4, 8, 0, 1'b0);
        push(9'h0A5);
        capture("a5_8N1", 4, 10, 16'h034A, 40);

        set_cfg(2, 7, 1, 1'b1);
        push(9'h035);
        capture("35_7E2", 2, 11, 16'h066A, 22);

        set_cfg(2, 7, 2, 1'b1);
        push(9'h035);
        capture("35_7O2", 2, 11, 16'h076A, 22);

        set_cfg(0, 3, 0, 1'b0);
        push(9'h0B3);
        capture("b3_cpb0_nb3", 1, 7, 16'h0066, 7);

        set_cfg(1, 9, 2, 1'b0);
        push(9'h1FF);
        capture("1ff_9O1", 1, 12, 16'h0BFE, 12);

        // Back-to-back frames: one continuous busy run, two done pulses.
        repeat (3) @(posedge clk); #2;
        set_cfg(3, 8, 0, 1'b0);
        done_cnt = 0;
        push(9'h001);
        push(9'h080);
        check("b2b_ready_low", 32'(tx_ready), 32'd0);
        guard = 0;
        while ((busy || run_len != 0) && guard < 500) begin
            @(posedge clk); #2;
            guard++;
        end
        @(negedge clk);
        check("b2b_run_len",  32'(last_run), 32'd60);
        check("b2b_done_cnt", 32'(done_cnt), 32'd2);

        // Reset in mid-frame with a second word buffered.
        @(posedge clk); #2;
        set_cfg(4, 8, 0, 1'b0);
        done_cnt = 0;
        push(9'h05A);
        push(9'h0C3);
        guard = 0;
        while (run_len < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check("abort_tx_s",  32'(tx_s),     32'd1);
        check("abort_busy",  32'(busy),     32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        repeat (60) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle",    32'(busy),     32'd0);

        // Randomised traffic with live configuration changes and rare resets.
        @(posedge clk); #2;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tx_valid = ($urandom % 3) == 0;
            tx_data  = DATA_MAX'($urandom);
            if (($urandom % 40) == 0)
                set_cfg($urandom % 4, $urandom % 16, $urandom % 4, 1'($urandom % 2));
            rst = (($urandom % 700) != 0);
            @(posedge clk); #2;
        end
        tx_valid = 1'b0;
        rst      = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("drain_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
